lfsr_step_counter: RTL and testbench

Parametrised LFSR counter for the trigger datapath of the AES core. Seeds from a slice of the 128-bit data bus and advances by a configurable number of shifts per enabled cycle, for any width and feedback polynomial. Compares each new state against a programmable match value and counts advances. Guards against the all-zero lock-up state.

---
 rtl/lfsr_step_counter.sv | 91 +++++++++
 tb/tb_lfsr_step_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_step_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lfsr_step_counter                                                |
// | Brief   : Fibonacci LFSR, STEPS shifts per trig cycle, with match and      |
// |           a saturating advance counter.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lfsr_step_counter #(
  parameter int                WIDTH        = 20,
  parameter logic [WIDTH-1:0]  TAPS         = WIDTH'(20'h08881),
  parameter int                STEPS        = 1,
  parameter int                DATA_W       = 128,
  parameter int                SEED_LSB     = 0,
  parameter logic [WIDTH-1:0]  SEED_DEFAULT = WIDTH'(1),
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              trig,
  input  logic              match_en,
  input  logic [WIDTH-1:0]  match_val,
  output logic [WIDTH-1:0]  lfsr,
  output logic              hit,
  output logic              hit_sticky,
  output logic              lockup,
  output logic [CNT_W-1:0]  step_cnt
);

  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_step_cnt;
  logic             r_hit;
  logic             r_hit_sticky;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic             w_seed_zero;
  logic             w_match;
  logic             w_unused_data;

  // Unrolled: STEPS applications of the single-shift function.
  always_comb begin
    w_next = r_lfsr;
    for (int i = 0; i < STEPS; i++) begin
      w_next = {^(w_next & TAPS), w_next[WIDTH-1:1]};
    end
  end

  assign w_seed        = data[SEED_LSB +: WIDTH];
  assign w_seed_zero   = (w_seed == '0);
  assign w_match       = match_en && (w_next == match_val);
  assign w_unused_data = ^data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr       <= SEED_DEFAULT;
      r_step_cnt   <= '0;
      r_hit        <= 1'b0;
      r_hit_sticky <= 1'b0;
      r_lockup     <= 1'b0;
    end else if (load) begin
      // A zero seed would lock the register up, so substitute the default.
      r_lfsr       <= w_seed_zero ? SEED_DEFAULT : w_seed;
      r_lockup     <= w_seed_zero;
      r_step_cnt   <= '0;
      r_hit        <= 1'b0;
      r_hit_sticky <= 1'b0;
    end else if (trig) begin
      r_lfsr       <= w_next;
      r_lockup     <= 1'b0;
      if (r_step_cnt != '1) begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
      r_hit        <= w_match;
      r_hit_sticky <= r_hit_sticky | w_match;
    end else begin
      r_hit        <= 1'b0;
      r_lockup     <= 1'b0;
    end
  end

  assign lfsr       = r_lfsr;
  assign hit        = r_hit;
  assign hit_sticky = r_hit_sticky;
  assign lockup     = r_lockup;
  assign step_cnt   = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_step_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lfsr_step_counter                                             |
// | Brief   : Scoreboard bench for three lfsr_step_counter configurations.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lfsr_step_counter;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] data;
  logic         trig;
  logic         match_en;
  logic [19:0]  match_val;

  logic [19:0] o0_lfsr, o1_lfsr, o2_lfsr;
  logic        o0_hit, o1_hit, o2_hit;
  logic        o0_sticky, o1_sticky, o2_sticky;
  logic        o0_lock, o1_lock, o2_lock;
  logic [31:0] o0_cnt, o1_cnt;
  logic [3:0]  o2_cnt;

  always #5 clk = ~clk;

  // u0: defaults, u1: four shifts per cycle, u2: 4-bit counter
  lfsr_step_counter u0 (
    .clk(clk), .rst(rst), .load(load), .data(data), .trig(trig),
    .match_en(match_en), .match_val(match_val), .lfsr(o0_lfsr), .hit(o0_hit),
    .hit_sticky(o0_sticky), .lockup(o0_lock), .step_cnt(o0_cnt));

  lfsr_step_counter #(.STEPS(4)) u1 (
    .clk(clk), .rst(rst), .load(load), .data(data), .trig(trig),
    .match_en(match_en), .match_val(match_val), .lfsr(o1_lfsr), .hit(o1_hit),
    .hit_sticky(o1_sticky), .lockup(o1_lock), .step_cnt(o1_cnt));

  lfsr_step_counter #(.CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .load(load), .data(data), .trig(trig),
    .match_en(match_en), .match_val(match_val), .lfsr(o2_lfsr), .hit(o2_hit),
    .hit_sticky(o2_sticky), .lockup(o2_lock), .step_cnt(o2_cnt));

  typedef struct packed {
    logic [2:0][19:0] lfsr;
    logic [2:0][31:0] cnt;
    logic [2:0]       hit;
    logic [2:0]       sticky;
    logic [2:0]       lock;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [19:0] m_lfsr   [3];
  logic [31:0] m_cnt    [3];
  logic        m_hit    [3];
  logic        m_sticky [3];
  logic        m_lock   [3];
  int          m_steps  [3] = '{1, 4, 1};
  logic [31:0] m_max    [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};

  function automatic logic [19:0] shift1(input logic [19:0] s);
    logic [19:0] taps;
    logic        fb;
    taps = 20'h08881;
    fb   = 1'b0;
    for (int b = 0; b < 20; b++) if (taps[b]) fb = fb ^ s[b];
    return {fb, s[19:1]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lfsr[k] = 20'h00001; m_cnt[k] = 0;
      m_hit[k] = 0; m_sticky[k] = 0; m_lock[k] = 0;
    end
  endtask

  task automatic model_step(input logic l, input logic t, input logic [127:0] d);
    logic [19:0] nx;
    for (int k = 0; k < 3; k++) begin
      if (l) begin
        m_lock[k]   = (d[19:0] == 20'h0);
        m_lfsr[k]   = m_lock[k] ? 20'h00001 : d[19:0];
        m_cnt[k]    = 0;
        m_hit[k]    = 0;
        m_sticky[k] = 0;
      end else if (t) begin
        nx = m_lfsr[k];
        for (int s = 0; s < m_steps[k]; s++) nx = shift1(nx);
        m_lfsr[k]   = nx;
        m_lock[k]   = 0;
        if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
        m_hit[k]    = match_en && (nx == match_val);
        m_sticky[k] = m_sticky[k] | m_hit[k];
      end else begin
        m_hit[k]  = 0;
        m_lock[k] = 0;
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.lfsr[k] = m_lfsr[k]; e.cnt[k] = m_cnt[k];
      e.hit[k] = m_hit[k]; e.sticky[k] = m_sticky[k]; e.lock[k] = m_lock[k];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input exp_t e, input string tag);
    chk({tag, " u0.lfsr"},   {12'b0, o0_lfsr},  {12'b0, e.lfsr[0]});
    chk({tag, " u1.lfsr"},   {12'b0, o1_lfsr},  {12'b0, e.lfsr[1]});
    chk({tag, " u2.lfsr"},   {12'b0, o2_lfsr},  {12'b0, e.lfsr[2]});
    chk({tag, " u0.cnt"},    o0_cnt,            e.cnt[0]);
    chk({tag, " u1.cnt"},    o1_cnt,            e.cnt[1]);
    chk({tag, " u2.cnt"},    {28'b0, o2_cnt},   e.cnt[2]);
    chk({tag, " hit"},       {29'b0, o2_hit, o1_hit, o0_hit},          {29'b0, e.hit});
    chk({tag, " sticky"},    {29'b0, o2_sticky, o1_sticky, o0_sticky}, {29'b0, e.sticky});
    chk({tag, " lockup"},    {29'b0, o2_lock, o1_lock, o0_lock},       {29'b0, e.lock});
  endtask

  task automatic step(input string tag, input logic l, input logic t, input logic [127:0] d);
    exp_t e;
    @(negedge clk);
    load = l; trig = t; data = d;
    model_step(l, t, d);
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_all(e, tag);
  endtask

  // Reset is dropped between edges and checked before the next edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all(snapshot(), tag);
    @(negedge clk);
    load = 0; trig = 0;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [19:0] seq_a [6] = '{20'h80000, 20'h40000, 20'h20000, 20'h10000, 20'h08000, 20'h84000};

  initial begin
    rst = 1'b1; load = 0; trig = 0; data = '0; match_en = 0; match_val = '0;
    model_reset();

    // Basic stepping with default taps
    do_reset("reset");
    for (int i = 0; i < 6; i++) begin
      step("seq", 1'b0, 1'b1, '0);
      chk("seq_const", {12'b0, o0_lfsr}, {12'b0, seq_a[i]});
    end
    chk("seq_cnt6", o0_cnt, 32'd6);
    step("hold", 1'b0, 1'b0, '0);

    // Four shifts per cycle
    do_reset("reset2");
    step("steps4", 1'b0, 1'b1, '0);
    chk("steps4_first", {12'b0, o1_lfsr}, 32'h10000);
    step("steps4_load", 1'b1, 1'b0, 128'h1);
    step("steps4_a", 1'b0, 1'b1, '0);
    step("steps4_b", 1'b0, 1'b1, '0);

    // Match pulse and sticky flag
    match_en = 1; match_val = 20'h20000;
    do_reset("reset3");
    for (int i = 1; i <= 5; i++) begin
      step("match", 1'b0, 1'b1, '0);
      chk("match_hit_u0", {31'b0, o0_hit}, {31'b0, (i == 3)});
      chk("match_sticky_u0", {31'b0, o0_sticky}, {31'b0, (i >= 3)});
    end
    step("match_idle", 1'b0, 1'b0, '0);
    step("match_clr", 1'b1, 1'b0, 128'h5);
    chk("sticky_cleared", {31'b0, o0_sticky}, 32'd0);
    match_en = 0;
    do_reset("reset4");
    for (int i = 0; i < 4; i++) step("nomatch", 1'b0, 1'b1, '0);

    // Zero seed substitution
    step("zero_seed", 1'b1, 1'b0, '0);
    chk("zero_seed_lock", {31'b0, o0_lock}, 32'd1);
    step("after_zero", 1'b0, 1'b1, '0);
    step("seed_abcde", 1'b1, 1'b0, {108'hF0F0, 20'hABCDE});
    chk("seed_abcde_val", {12'b0, o0_lfsr}, 32'hABCDE);

    // Load wins over trig; no hit on a load cycle
    match_en = 1; match_val = 20'h12345;
    step("load_trig", 1'b1, 1'b1, 128'h12345);
    chk("load_trig_cnt", o0_cnt, 32'd0);
    step("load_trig_hold", 1'b0, 1'b0, '0);
    match_en = 0;

    // Counter saturation then asynchronous reset mid-run
    do_reset("reset5");
    for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b1, '0);
    chk("sat_u2", {28'b0, o2_cnt}, 32'd15);
    chk("sat_u0", o0_cnt, 32'd20);
    @(negedge clk);
    trig = 1;
    do_reset("midrun_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
